// File: rtl/utpu_isa_pkg.sv
// utpu_isa_pkg
//   Shared instruction-set definitions for the uTPU command path. The
//   encoder packs commands into this format and the decoding controller
//   unpacks them, so both sides must import the same field positions.
//   Contents: default width constants, instruction field positions,
//   the opcode enumeration and small opcode classification helpers.
package utpu_isa_pkg;

  // Default widths of the instruction/data path.
  localparam int BUFFER_WORD_SIZE_DEF = 16;
  localparam int FIFO_DATA_WIDTH_DEF  = 8;
  localparam int ADDRESS_SIZE_DEF     = 9;
  localparam int OPCODE_WIDTH_DEF     = 3;

  // Instruction word field positions. Bit 6 is reserved and always 0.
  localparam int OPCODE_LSB  = 0;
  localparam int FLAGS_LSB   = 3;
  localparam int FLAGS_WIDTH = 3;
  localparam int ADDR_LSB    = 7;

  // Flag bit that asks STORE to send an explicit address word.
  localparam int STORE_ADDR_FLAG_BIT = 1;

  typedef enum logic [OPCODE_WIDTH_DEF-1:0] {
    OP_STORE = 3'd0,
    OP_FETCH = 3'd1,
    OP_RUN   = 3'd2,
    OP_LOAD  = 3'd3,
    OP_HALT  = 3'd4,
    OP_NOP   = 3'd5
  } opcode_e;

  // Opcodes 6 and 7 are unassigned.
  function automatic logic is_legal_opcode(input logic [OPCODE_WIDTH_DEF-1:0] op);
    return (op <= OP_NOP);
  endfunction

  // Opcodes whose instruction word carries the buffer address in [15:7].
  function automatic logic opcode_carries_address(input logic [OPCODE_WIDTH_DEF-1:0] op);
    return (op == OP_FETCH) || (op == OP_RUN) || (op == OP_LOAD);
  endfunction

endpackage

// File: rtl/instr_encoder.sv
// instr_encoder
//   Turns one command (opcode, flags, address, data) into a byte stream for
//   the TX FIFO. Every command produces a 16-bit instruction word; STORE
//   additionally sends an optional address word and a data word. Words go
//   out low byte first. One FSM walks the bytes; each state names the byte
//   currently held on byte_data.
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   cmd_valid/ready   command handshake; ready only while idle
//   cmd_opcode        STORE=0 FETCH=1 RUN=2 LOAD=3 HALT=4 NOP=5 (6,7 illegal)
//   cmd_flags         copied into instruction bits [5:3]
//   cmd_address       buffer address
//   cmd_data          STORE payload
//   byte_valid/ready  byte handshake towards the TX FIFO
//   byte_data         serialized byte, registered and held while stalled
//   busy              high whenever the FSM is not idle
//   illegal_op        one-cycle pulse when an opcode 6/7 command is dropped
module instr_encoder
  import utpu_isa_pkg::*;
#(
  parameter int BUFFER_WORD_SIZE = BUFFER_WORD_SIZE_DEF,
  parameter int FIFO_DATA_WIDTH  = FIFO_DATA_WIDTH_DEF,
  parameter int ADDRESS_SIZE     = ADDRESS_SIZE_DEF,
  parameter int OPCODE_WIDTH     = OPCODE_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [OPCODE_WIDTH-1:0]     cmd_opcode,
  input  logic [FLAGS_WIDTH-1:0]      cmd_flags,
  input  logic [ADDRESS_SIZE-1:0]     cmd_address,
  input  logic [BUFFER_WORD_SIZE-1:0] cmd_data,
  output logic                        byte_valid,
  input  logic                        byte_ready,
  output logic [FIFO_DATA_WIDTH-1:0]  byte_data,
  output logic                        busy,
  output logic                        illegal_op
);

  localparam int BW = FIFO_DATA_WIDTH;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_INSTR_LO = 3'd1;
  localparam logic [2:0] S_INSTR_HI = 3'd2;
  localparam logic [2:0] S_ADDR_LO  = 3'd3;
  localparam logic [2:0] S_ADDR_HI  = 3'd4;
  localparam logic [2:0] S_DATA_LO  = 3'd5;
  localparam logic [2:0] S_DATA_HI  = 3'd6;

  logic [2:0]                  r_state;
  logic [BW-1:0]               r_instr_hi;
  logic [BUFFER_WORD_SIZE-1:0] r_addr_word;
  logic [BUFFER_WORD_SIZE-1:0] r_data_word;
  logic                        r_has_addr;
  logic                        r_has_data;
  logic                        r_byte_valid;
  logic [BW-1:0]               r_byte_data;
  logic                        r_illegal_op;

  logic [BUFFER_WORD_SIZE-1:0] w_instr_word;
  logic [BUFFER_WORD_SIZE-1:0] w_addr_word;
  logic                        w_is_store;
  logic                        w_fire;

  // Instruction word assembly from the live command fields; only sampled
  // on the accepting cycle, so later input changes cannot leak in.
  always_comb begin
    w_instr_word = '0;
    w_instr_word[OPCODE_LSB +: OPCODE_WIDTH] = cmd_opcode;
    w_instr_word[FLAGS_LSB +: FLAGS_WIDTH]   = cmd_flags;
    if (opcode_carries_address(cmd_opcode)) begin
      w_instr_word[ADDR_LSB +: ADDRESS_SIZE] = cmd_address;
    end
  end

  assign w_addr_word = BUFFER_WORD_SIZE'(cmd_address);
  assign w_is_store  = (cmd_opcode == OP_STORE);

  // A byte leaves only when the sink takes it; otherwise everything holds.
  assign w_fire = r_byte_valid & byte_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_instr_hi   <= '0;
      r_addr_word  <= '0;
      r_data_word  <= '0;
      r_has_addr   <= 1'b0;
      r_has_data   <= 1'b0;
      r_byte_valid <= 1'b0;
      r_byte_data  <= '0;
      r_illegal_op <= 1'b0;
    end else begin
      r_illegal_op <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (is_legal_opcode(cmd_opcode)) begin
              // Low instruction byte is presented straight away so the
              // first byte_valid appears one cycle after acceptance.
              r_instr_hi   <= w_instr_word[BW +: BW];
              r_addr_word  <= w_addr_word;
              r_data_word  <= cmd_data;
              r_has_addr   <= w_is_store & cmd_flags[STORE_ADDR_FLAG_BIT];
              r_has_data   <= w_is_store;
              r_byte_data  <= w_instr_word[0 +: BW];
              r_byte_valid <= 1'b1;
              r_state      <= S_INSTR_LO;
            end else begin
              // Illegal opcodes are consumed and dropped.
              r_illegal_op <= 1'b1;
            end
          end
        end
        S_INSTR_LO: begin
          if (w_fire) begin
            r_byte_data <= r_instr_hi;
            r_state     <= S_INSTR_HI;
          end
        end
        S_INSTR_HI: begin
          if (w_fire) begin
            if (r_has_addr) begin
              r_byte_data <= r_addr_word[0 +: BW];
              r_state     <= S_ADDR_LO;
            end else if (r_has_data) begin
              r_byte_data <= r_data_word[0 +: BW];
              r_state     <= S_DATA_LO;
            end else begin
              r_byte_data  <= '0;
              r_byte_valid <= 1'b0;
              r_state      <= S_IDLE;
            end
          end
        end
        S_ADDR_LO: begin
          if (w_fire) begin
            r_byte_data <= r_addr_word[BW +: BW];
            r_state     <= S_ADDR_HI;
          end
        end
        S_ADDR_HI: begin
          // An address word is only ever sent by STORE, so data follows.
          if (w_fire) begin
            r_byte_data <= r_data_word[0 +: BW];
            r_state     <= S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          if (w_fire) begin
            r_byte_data <= r_data_word[BW +: BW];
            r_state     <= S_DATA_HI;
          end
        end
        S_DATA_HI: begin
          if (w_fire) begin
            r_byte_data  <= '0;
            r_byte_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_byte_data  <= '0;
          r_byte_valid <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  // cmd_ready is low during the final byte handshake, so a new command can
  // never be taken in the same cycle the previous one finishes.
  assign cmd_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign byte_valid = r_byte_valid;
  assign byte_data  = r_byte_data;
  assign illegal_op = r_illegal_op;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
  localparam int W = 16;
  localparam int B = 8;
  localparam int A = 9;
  localparam int O = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [O-1:0]  cmd_opcode = '0;
  logic [2:0]    cmd_flags = '0;
  logic [A-1:0]  cmd_address = '0;
  logic [W-1:0]  cmd_data = '0;
  logic          byte_valid;
  logic          byte_ready = 1'b1;
  logic [B-1:0]  byte_data;
  logic          busy;
  logic          illegal_op;

  instr_encoder #(
    .BUFFER_WORD_SIZE(W),
    .FIFO_DATA_WIDTH(B),
    .ADDRESS_SIZE(A),
    .OPCODE_WIDTH(O)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode),
    .cmd_flags(cmd_flags),
    .cmd_address(cmd_address),
    .cmd_data(cmd_data),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .byte_data(byte_data),
    .busy(busy),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Reference model: the bytes still owed to the sink, plus the illegal pulse.
  logic [7:0] exp_q[$];
  logic       exp_illegal = 1'b0;

  // Observed handshakes and a few event counters for the directed checks.
  logic [7:0] got_q[$];
  int         got_cyc[$];
  int         held_cnt = 0;
  int         ill_cnt = 0;
  int         bv_cnt = 0;
  int         busy_cnt = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic void push_word(input int w);
    exp_q.push_back(8'(w & 255));
    exp_q.push_back(8'((w >> 8) & 255));
  endfunction

  // Byte list of a legal command, straight from the instruction format rules.
  function automatic void model_push(input int op, input int fl, input int ad, input int da);
    int instr;
    instr = op + fl * 8;
    if (op == 1 || op == 2 || op == 3) instr = instr + ad * 128;
    push_word(instr & 16'hFFFF);
    if (op == 0) begin
      if ((fl & 2) != 0) push_word(ad);
      push_word(da);
    end
  endfunction

  // Compare DUT outputs with the model, then advance the model to what the
  // next rising edge must produce from the inputs now being applied.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      exp_illegal = 1'b0;
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_byte_valid", byte_valid, 0);
      chk("rst_byte_data", byte_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_illegal", illegal_op, 0);
    end else begin
      chk("cmd_ready", cmd_ready, exp_q.size() == 0);
      chk("busy", busy, exp_q.size() != 0);
      chk("byte_valid", byte_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) chk("byte_data", byte_data, exp_q[0]);
      chk("illegal_op", illegal_op, exp_illegal);

      if (byte_valid && !byte_ready && byte_data == 8'h9A) held_cnt++;
      if (illegal_op) ill_cnt++;
      if (byte_valid) bv_cnt++;
      if (busy) busy_cnt++;
      if (byte_valid && byte_ready) begin
        got_q.push_back(byte_data);
        got_cyc.push_back(cyc);
      end

      exp_illegal = 1'b0;
      if (exp_q.size() != 0) begin
        if (byte_ready) void'(exp_q.pop_front());
      end else if (cmd_valid) begin
        if (int'(cmd_opcode) >= 6) exp_illegal = 1'b1;
        else model_push(int'(cmd_opcode), int'(cmd_flags), int'(cmd_address), int'(cmd_data));
      end
    end
  end

  task automatic scramble_cmd();
    cmd_opcode  = 3'($urandom_range(0, 7));
    cmd_flags   = 3'($urandom);
    cmd_address = 9'($urandom);
    cmd_data    = 16'($urandom);
  endtask

  // Called just after a rising edge with the DUT idle; returns just after
  // the accepting edge with junk left on the command fields.
  task automatic send(input int op, input int fl, input int ad, input int da);
    cmd_valid   = 1'b1;
    cmd_opcode  = 3'(op);
    cmd_flags   = 3'(fl);
    cmd_address = 9'(ad);
    cmd_data    = 16'(da);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    scramble_cmd();
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || byte_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_timeout"}, busy || byte_valid, 0);
  endtask

  task automatic chk_log(input string name, input logic [7:0] e[$]);
    chk({name, "_count"}, got_q.size(), e.size());
    for (int i = 0; i < e.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s_byte%0d", name, i), got_q[i], e[i]);
    end
  endtask

  initial begin
    logic [7:0] e[$];

    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // RUN right after reset release, full throughput.
    got_q.delete(); got_cyc.delete();
    send(2, 3'b011, 9'h0A5, 16'h5555);
    wait_idle("run");
    e = '{8'h9A, 8'h52};
    chk_log("run", e);
    if (got_cyc.size() >= 2) chk("run_no_bubble", got_cyc[1] - got_cyc[0], 1);
    chk("run_ready_after", cmd_ready, 1);

    // STORE with address word.
    got_q.delete();
    send(0, 3'b010, 9'h1FF, 16'hBEEF);
    wait_idle("store6");
    e = '{8'h10, 8'h00, 8'hFF, 8'h01, 8'hEF, 8'hBE};
    chk_log("store6", e);

    // STORE without address word.
    got_q.delete();
    send(0, 3'b000, 9'h0C3, 16'h1234);
    wait_idle("store4");
    e = '{8'h00, 8'h00, 8'h34, 8'h12};
    chk_log("store4", e);

    // RUN with the sink stalled for 5 cycles on the first byte.
    got_q.delete();
    held_cnt = 0;
    cmd_valid = 1'b1; cmd_opcode = 3'd2; cmd_flags = 3'b011;
    cmd_address = 9'h0A5; cmd_data = 16'h0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    byte_ready = 1'b0;
    scramble_cmd();
    repeat (5) @(posedge clk);
    #1 byte_ready = 1'b1;
    wait_idle("stall");
    chk("stall_held_cycles", held_cnt, 5);
    e = '{8'h9A, 8'h52};
    chk_log("stall", e);

    // Illegal opcode.
    ill_cnt = 0; bv_cnt = 0; busy_cnt = 0;
    send(7, 3'b111, 9'h1AA, 16'hFFFF);
    repeat (4) @(posedge clk);
    #1;
    chk("illegal_pulse_cycles", ill_cnt, 1);
    chk("illegal_byte_valid_cycles", bv_cnt, 0);
    chk("illegal_busy_cycles", busy_cnt, 0);

    // Reset after the third byte of a 6-byte STORE, then a NOP.
    got_q.delete();
    send(0, 3'b010, 9'h1FF, 16'hBEEF);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    e = '{8'h10, 8'h00, 8'hFF};
    chk_log("pre_reset", e);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    got_q.delete();
    send(5, 3'b000, 9'h000, 16'h0000);
    wait_idle("nop");
    e = '{8'h05, 8'h00};
    chk_log("post_reset_nop", e);

    // Randomized traffic, including commands presented while busy and
    // occasional reset pulses; the model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      cmd_valid  = ($urandom_range(0, 99) < 35);
      scramble_cmd();
      byte_ready = ($urandom_range(0, 99) < 70);
      rst        = ($urandom_range(0, 499) == 0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    cmd_valid = 1'b0;
    byte_ready = 1'b1;
    wait_idle("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
